// File: rtl/gray_count_rx.sv
// gray_count_rx
//   Local-domain monitor for a remote free-running counter published Gray-coded.
//   The Gray count is synchronized into clk, decoded to binary, and turned into
//   a wrapping running total, a saturating per-window increment rate, and a
//   sticky flag for illegal multi-bit Gray transitions.
//
// Ports
//   clk        : local clock
//   rst        : synchronous active-high reset, clears every register
//   gray_in    : Gray-coded remote count, asynchronous to clk
//   clr_err    : clears err (an illegal jump detected in the same cycle wins)
//   count_bin  : last synchronized count in binary
//   total      : increments accumulated since reset, wraps mod 2^TOTAL_W
//   rate       : increments in the last completed window, saturating
//   rate_valid : one-cycle pulse when rate updates
//   err        : sticky illegal-transition flag
module gray_count_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 256,
  parameter int RATE_W      = 16,
  parameter int TOTAL_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   gray_in,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   count_bin,
  output logic [TOTAL_W-1:0] total,
  output logic [RATE_W-1:0]  rate,
  output logic               rate_valid,
  output logic               err
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam int SUM_W  = ((RATE_W > WIDTH) ? RATE_W : WIDTH) + 1;

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [RATE_W-1:0] sat_add(input logic [RATE_W-1:0] a,
                                                input logic [WIDTH-1:0]  d);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(d);
    if (sum > SUM_W'({RATE_W{1'b1}})) begin
      return {RATE_W{1'b1}};
    end
    return sum[RATE_W-1:0];
  endfunction

  // More than one bit set: x & (x-1) removes the lowest set bit.
  function automatic logic multi_bit(input logic [WIDTH-1:0] x);
    return |(x & (x - WIDTH'(1)));
  endfunction

  logic [WIDTH-1:0]   s_q [SYNC_STAGES];
  logic [WIDTH-1:0]   s_d [SYNC_STAGES];
  logic [WIDTH-1:0]   prev_gray_q, prev_gray_d;
  logic [WIDTH-1:0]   prev_bin_q, prev_bin_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [RATE_W-1:0]  acc_q, acc_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic               rate_valid_q, rate_valid_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   sg;
  logic [WIDTH-1:0]   bin;
  logic [WIDTH-1:0]   delta;
  logic               warm_done;
  logic               illegal;

  assign sg        = s_q[SYNC_STAGES-1];
  assign bin       = gray2bin(sg);
  // Modular subtraction makes a counter wrap (e.g. max -> 0) a small positive delta.
  assign delta     = bin - prev_bin_q;
  assign warm_done = (warm_cnt_q == WARM_LAST);
  assign illegal   = multi_bit(sg ^ prev_gray_q);

  always_comb begin
    s_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      s_d[i] = s_q[i-1];
    end
    prev_gray_d  = sg;
    prev_bin_d   = bin;
    warm_cnt_d   = warm_cnt_q;
    total_d      = total_q;
    acc_d        = acc_q;
    win_cnt_d    = win_cnt_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    err_d        = err_q;

    // Until the chain and history hold real samples, the first delta would be
    // the reset-to-count jump; suppress all accounting until then.
    if (!warm_done) begin
      warm_cnt_d = warm_cnt_q + WARM_W'(1);
    end else begin
      total_d = total_q + TOTAL_W'(delta);
      if (win_cnt_q == WIN_LAST) begin
        // Terminal cycle's delta closes the current window.
        rate_d       = sat_add(acc_q, delta);
        rate_valid_d = 1'b1;
        acc_d        = '0;
        win_cnt_d    = '0;
      end else begin
        acc_d     = sat_add(acc_q, delta);
        win_cnt_d = win_cnt_q + WIN_W'(1);
      end
      if (clr_err) begin
        err_d = 1'b0;
      end
      if (illegal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        s_q[i] <= '0;
      end
      prev_gray_q  <= '0;
      prev_bin_q   <= '0;
      warm_cnt_q   <= '0;
      total_q      <= '0;
      acc_q        <= '0;
      win_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        s_q[i] <= s_d[i];
      end
      prev_gray_q  <= prev_gray_d;
      prev_bin_q   <= prev_bin_d;
      warm_cnt_q   <= warm_cnt_d;
      total_q      <= total_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      err_q        <= err_d;
    end
  end

  assign count_bin  = prev_bin_q;
  assign total      = total_q;
  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gray_count_rx.sv
// tb_gray_count_rx
//   Randomized and directed stimulus for gray_count_rx, checked every cycle
//   against a reference built from the history of driven Gray values.
module tb_gray_count_rx;

  localparam int N      = 2;
  localparam int WINDOW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gray_in;
  logic        clr_err;
  logic [7:0]  count_bin;
  logic [31:0] total;
  logic [7:0]  rate;
  logic        rate_valid;
  logic        err;

  gray_count_rx #(
    .WIDTH(8), .SYNC_STAGES(N), .WINDOW(WINDOW), .RATE_W(8), .TOTAL_W(32)
  ) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .clr_err(clr_err),
    .count_bin(count_bin), .total(total), .rate(rate),
    .rate_valid(rate_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: edges since reset release and the Gray value sampled at each.
  int          e;
  logic [7:0]  gh [0:4095];
  logic [31:0] exp_total;
  int          wsum;
  logic [7:0]  exp_rate;
  logic [7:0]  exp_cnt;
  logic        exp_rv;
  logic        exp_err;

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [7:0] from_gray(input logic [7:0] g);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 8; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [7:0] gd(input int k);
    return (k >= 1) ? gh[k] : 8'h00;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("count_bin", 64'(count_bin), 64'(exp_cnt));
    check_eq("total", 64'(total), 64'(exp_total));
    check_eq("rate", 64'(rate), 64'(exp_rate));
    check_eq("rate_valid", 64'(rate_valid), 64'(exp_rv));
    check_eq("err", 64'(err), 64'(exp_err));
  endtask

  task automatic model_clear();
    e = 0; exp_total = 0; wsum = 0; exp_rate = 0; exp_cnt = 0; exp_rv = 0; exp_err = 0;
  endtask

  task automatic model_edge(input logic [7:0] g, input logic clr);
    logic [7:0] d;
    int c;
    e++;
    if (e < 4096) gh[e] = g;
    exp_cnt = from_gray(gd(e - N));
    exp_rv  = 1'b0;
    if (e >= N + 2) begin
      d = from_gray(gd(e - N)) - from_gray(gd(e - N - 1));
      exp_total = exp_total + 32'(d);
      wsum = wsum + int'(d);
      c = e - N - 1;
      if (c % WINDOW == 0) begin
        exp_rate = (wsum > 255) ? 8'hFF : 8'(wsum);
        exp_rv   = 1'b1;
        wsum     = 0;
      end
      if ($countones(gd(e - N) ^ gd(e - N - 1)) > 1) exp_err = 1'b1;
      else if (clr) exp_err = 1'b0;
    end
  endtask

  task automatic tick(input logic [7:0] g, input logic clr);
    gray_in = g;
    clr_err = clr;
    @(posedge clk);
    model_edge(g, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    clr_err = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      model_clear();
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b0;
  endtask

  logic [7:0]  cur;
  logic [31:0] t0, ta;
  int          pulses;
  int          first;
  int          r;

  initial begin
    rst = 1'b1;
    clr_err = 1'b0;
    gray_in = to_gray(8'h37);
    model_clear();
    @(negedge clk);

    // Reset and warm-up with a held value
    do_reset(3);
    repeat (3) tick(to_gray(8'h37), 1'b0);
    check_eq("warm_count_bin", 64'(count_bin), 64'h37);
    check_eq("warm_total", 64'(total), 64'd0);
    check_eq("warm_err", 64'(err), 64'd0);

    // Steady rate: +1 every 2 cycles
    cur = 8'h37;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 2 == 0) cur = cur + 8'd1;
      tick(to_gray(cur), 1'b0);
      if (rate_valid) begin
        pulses++;
        if (pulses > 1) check_eq("steady_rate", 64'(rate), 64'd8);
      end
    end
    check_eq("steady_pulses", 64'(pulses), 64'd4);
    repeat (2) tick(to_gray(cur), 1'b0);
    check_eq("steady_total", 64'(total), 64'd32);

    // Wrap 0xFC..0x03
    gray_in = to_gray(8'hFC);
    do_reset(2);
    repeat (4) tick(to_gray(8'hFC), 1'b0);
    t0 = total;
    cur = 8'hFC;
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) cur = cur + 8'd1;
      tick(to_gray(cur), 1'b0);
    end
    repeat (3) tick(to_gray(cur), 1'b0);
    check_eq("wrap_total", 64'(total - t0), 64'd7);
    check_eq("wrap_err", 64'(err), 64'd0);

    // Illegal jump 0 -> 5
    gray_in = to_gray(8'h00);
    do_reset(2);
    repeat (4) tick(to_gray(8'h00), 1'b0);
    t0 = total;
    tick(to_gray(8'h05), 1'b0);
    tick(to_gray(8'h05), 1'b0);
    check_eq("jump_err_early", 64'(err), 64'd0);
    tick(to_gray(8'h05), 1'b0);
    check_eq("jump_err_set", 64'(err), 64'd1);
    repeat (3) tick(to_gray(8'h05), 1'b0);
    check_eq("jump_err_sticky", 64'(err), 64'd1);
    check_eq("jump_total", 64'(total - t0), 64'd5);
    tick(to_gray(8'h05), 1'b1);
    check_eq("jump_err_clr", 64'(err), 64'd0);
    repeat (4) tick(to_gray(8'h00), 1'b0);
    tick(to_gray(8'h00), 1'b1);
    check_eq("jump_err_clr2", 64'(err), 64'd0);
    repeat (3) tick(to_gray(8'h05), 1'b1);
    check_eq("jump_set_wins", 64'(err), 64'd1);
    tick(to_gray(8'h05), 1'b0);

    // Saturation: alternate 0x00 / 0x80
    gray_in = to_gray(8'h00);
    do_reset(2);
    repeat (3) tick(to_gray(8'h00), 1'b0);
    pulses = 0;
    ta = 0;
    for (int i = 0; i < 48; i++) begin
      tick((i % 2 == 0) ? to_gray(8'h80) : to_gray(8'h00), 1'b0);
      if (i == 10) ta = total;
      if (i == 30) check_eq("sat_total_step", 64'(total - ta), 64'(20 * 128));
      if (rate_valid) begin
        pulses++;
        check_eq("sat_rate", 64'(rate), 64'hFF);
      end
    end
    check_eq("sat_pulses", 64'(pulses), 64'd3);

    // Reset at win_cnt = 9
    gray_in = to_gray(8'h10);
    do_reset(2);
    repeat (3) tick(to_gray(8'h10), 1'b0);
    cur = 8'h10;
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) cur = cur + 8'd1;
      tick(to_gray(cur), 1'b0);
    end
    do_reset(1);
    check_eq("rst_total", 64'(total), 64'd0);
    check_eq("rst_rv", 64'(rate_valid), 64'd0);
    first = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j % 2 == 0) cur = cur + 8'd1;
      tick(to_gray(cur), 1'b0);
      if (rate_valid && first == 0) first = j;
    end
    check_eq("rst_first_pulse", 64'(first), 64'(N + 1 + WINDOW));

    // Randomized: holds, +/-1 steps, arbitrary jumps, random clears
    cur = 8'($urandom);
    gray_in = to_gray(cur);
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) cur = cur;
      else if (r < 85) cur = cur + 8'd1;
      else if (r < 90) cur = cur - 8'd1;
      else cur = 8'($urandom);
      tick(to_gray(cur), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
